// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter and dump sequencer.
// The width/limit defaults are also used by the main-memory and CPU top levels.
package data_mem_arbiter_pkg;

   localparam int DEF_ADDR_W       = 9;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } dumpState_t;

endpackage

// File: rtl/data_mem_arbiter_out_reg.sv
// Valid/ready holding register for dumped words.
// A capture may happen in the same cycle as a handshake, which gives one word per cycle.
module dump_out_reg
   import data_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              captureEn,
   input  logic [ADDR_W-1:0] captureIndex,
   input  logic [DATA_W-1:0] captureData,
   input  logic              outReady,
   output logic              outValid,
   output logic [ADDR_W-1:0] outIndex,
   output logic [DATA_W-1:0] outData,
   output logic              handshake
);

   assign handshake = outValid & outReady;

   // Load a new word on capture; otherwise drop valid once the consumer has taken the word.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         outValid <= 1'b0;
         outIndex <= '0;
         outData  <= '0;
      end else if (captureEn) begin
         outValid <= 1'b1;
         outIndex <= captureIndex;
         outData  <= captureData;
      end else if (handshake) begin
         outValid <= 1'b0;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between MEM-stage loads/stores and the dump engine.
// The dump engine uses idle slots; after STARVE_LIMIT denied cycles it takes a slot by
// stalling the pipeline for one cycle. The CPU path is purely combinational.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              CpuMemREQ,
   input  logic              CpuMemWE,
   input  logic [31:0]       CpuAddr,
   input  logic [DATA_W-1:0] CpuWrData,
   output logic [DATA_W-1:0] CpuRdData,
   output logic              CpuStall,
   input  logic              DumpStart,
   output logic              DumpBusy,
   output logic              DumpValid,
   input  logic              DumpReady,
   output logic [ADDR_W-1:0] DumpIndex,
   output logic [DATA_W-1:0] DumpData,
   output logic              DumpDone,
   output logic              RamWE,
   output logic [ADDR_W-1:0] RamIndex,
   output logic [DATA_W-1:0] RamWrData,
   input  logic [DATA_W-1:0] RamRdData
);

   localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   dumpState_t          state;
   logic [ADDR_W:0]     scanPtr;
   logic [STARVE_W-1:0] starveCount;
   logic                dumpWant;
   logic                forcedGrant;
   logic                dumpGrant;
   logic                handshake;
   logic                unusedAddrBits;

   // The top pointer bit marks that every word has been read.
   assign dumpWant    = (state == SCAN) && !scanPtr[ADDR_W] && (!DumpValid || DumpReady);
   assign forcedGrant = dumpWant && CpuMemREQ && (starveCount == STARVE_MAX);
   assign dumpGrant   = dumpWant && (!CpuMemREQ || forcedGrant);

   assign CpuStall       = forcedGrant;
   assign RamWE          = CpuMemREQ && CpuMemWE && !dumpGrant;
   assign RamIndex       = dumpGrant ? scanPtr[ADDR_W-1:0] : CpuAddr[ADDR_W+1:2];
   assign RamWrData      = CpuWrData;
   assign CpuRdData      = RamRdData;
   assign unusedAddrBits = ^{CpuAddr[31:ADDR_W+2], CpuAddr[1:0]};

   dump_out_reg #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) outReg (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .captureEn   (dumpGrant),
      .captureIndex(scanPtr[ADDR_W-1:0]),
      .captureData (RamRdData),
      .outReady    (DumpReady),
      .outValid    (DumpValid),
      .outIndex    (DumpIndex),
      .outData     (DumpData),
      .handshake   (handshake)
   );

   // Dump sequencing FSM with scan pointer, starve counter and registered busy/done flags.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state       <= IDLE;
         scanPtr     <= '0;
         starveCount <= '0;
         DumpBusy    <= 1'b0;
         DumpDone    <= 1'b0;
      end else begin
         DumpDone <= 1'b0;
         case (state)
            IDLE: begin
               starveCount <= '0;
               if (DumpStart) begin
                  scanPtr  <= '0;
                  DumpBusy <= 1'b1;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (dumpGrant) begin
                  scanPtr     <= scanPtr + 1'b1;
                  starveCount <= '0;
                  if (scanPtr[ADDR_W-1:0] == '1) begin
                     state <= DRAIN;
                  end
               end else if (dumpWant && (starveCount != STARVE_MAX)) begin
                  starveCount <= starveCount + 1'b1;
               end
            end
            DRAIN: begin
               if (handshake) begin
                  DumpBusy <= 1'b0;
                  DumpDone <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
